// File: rtl/array_shift_pkg.sv
// Shared types and default widths for the array shift engine.
package array_shift_pkg;

    localparam int DEF_ELEM_W   = 12;
    localparam int DEF_N_AREA   = 4;
    localparam int DEF_N_ARRAYS = 2;

    typedef enum logic [1:0] {
        OP_WRITE      = 2'd0,
        OP_RESIZE     = 2'd1,
        OP_SHIFT_UP   = 2'd2,
        OP_SHIFT_DOWN = 2'd3
    } op_t;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CHECK  = 3'd1,
        S_MOVE   = 3'd2,
        S_COMMIT = 3'd3,
        S_DONE   = 3'd4
    } state_t;

endpackage

// File: rtl/array_shift_engine_if.sv
// Command port and read port of the array shift engine.
interface array_shift_engine_if #(
    parameter int MemoryElementWidth = 12
);

    logic                          cmd_valid;
    logic                          cmd_ready;
    logic [1:0]                    cmd_op;
    logic [MemoryElementWidth-1:0] cmd_array;
    logic [MemoryElementWidth-1:0] cmd_index;
    logic [MemoryElementWidth-1:0] cmd_value;
    logic                          done;
    logic                          err;
    logic [MemoryElementWidth-1:0] result;
    logic [MemoryElementWidth-1:0] rd_array;
    logic [MemoryElementWidth-1:0] rd_index;
    logic [MemoryElementWidth-1:0] rd_data;
    logic [MemoryElementWidth-1:0] rd_size;

    modport master (
        output cmd_valid, cmd_op, cmd_array, cmd_index, cmd_value, rd_array, rd_index,
        input  cmd_ready, done, err, result, rd_data, rd_size
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_array, cmd_index, cmd_value, rd_array, rd_index,
        output cmd_ready, done, err, result, rd_data, rd_size
    );

endinterface

// File: rtl/array_heap_ram.sv
// Heap storage: one synchronous write port, an asynchronous mover read
// port and a registered fetch read port.
module array_heap_ram #(
    parameter int W     = 12,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] mv_addr,
    output logic [W-1:0]  mv_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [W-1:0]  rd_data
);

    logic [W-1:0] mem [DEPTH];

    // Heap write; contents are deliberately not reset.
    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign mv_data = mem[mv_addr];

    // Fetch port register; a same-edge write is not forwarded, so the old value is returned.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_data <= '0;
        end else begin
            rd_data <= rd_en ? mem[rd_addr] : '0;
        end
    end

endmodule

// File: rtl/array_shift_engine.sv
// Multi-cycle array instruction engine: moves one heap element per clock
// for inserts and deletes, and owns the per-array size table.
module array_shift_engine
    import array_shift_pkg::*;
#(
    parameter int MemoryElementWidth = DEF_ELEM_W,
    parameter int NArea              = DEF_N_AREA,
    parameter int NArrays            = DEF_N_ARRAYS,
    parameter int AW                 = $clog2(NArea*NArrays)
) (
    input  logic                  clock,
    input  logic                  reset,
    array_shift_engine_if.slave   bus
);

    localparam int W  = MemoryElementWidth;
    localparam int SW = (NArrays > 1) ? $clog2(NArrays) : 1;
    localparam logic [W-1:0] AREA_W   = W'(NArea);
    localparam logic [W-1:0] ARRAYS_W = W'(NArrays);

    state_t state, state_nx;
    logic   accept;

    op_t          op_q;
    logic [W-1:0] arr_q, idx_q, val_q;
    logic [W-1:0] size_tab [NArrays];
    logic [W-1:0] size_q, k_q, cnt_q, result_q;
    logic         err_q;

    logic          arr_bad;
    logic [SW-1:0] arr_sel;
    logic [AW-1:0] cur_base;
    logic [W-1:0]  cur_size;
    logic          chk_err;
    logic [W-1:0]  chk_moves, chk_k, chk_result;
    logic [W-1:0]  commit_size;

    logic          we;
    logic [AW-1:0] waddr, mv_addr, rd_addr;
    logic [W-1:0]  wdata, mv_data;
    logic          rd_ok;

    assign accept   = bus.cmd_valid && (state == S_IDLE);
    assign arr_bad  = (arr_q >= ARRAYS_W);
    assign arr_sel  = SW'(arr_q);
    assign cur_base = AW'(arr_q) * AW'(NArea);
    assign cur_size = arr_bad ? '0 : size_tab[arr_sel];

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state: illegal commands skip straight to DONE, zero-move commands skip MOVE.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   if (accept) state_nx = S_CHECK;
            S_CHECK:  state_nx = chk_err ? S_DONE : ((chk_moves != '0) ? S_MOVE : S_COMMIT);
            S_MOVE:   if (cnt_q == W'(1)) state_nx = S_COMMIT;
            S_COMMIT: state_nx = S_DONE;
            S_DONE:   state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    // Outputs decoded from the state register; err and result are only shown alongside done.
    always_comb begin
        bus.cmd_ready = (state == S_IDLE);
        bus.done      = (state == S_DONE);
        bus.err       = (state == S_DONE) && err_q;
        bus.result    = (state == S_DONE) ? result_q : '0;
    end

    // Legality check, move count, starting position and retire value for the latched command.
    always_comb begin
        chk_err    = arr_bad;
        chk_moves  = '0;
        chk_k      = '0;
        chk_result = '0;
        case (op_q)
            OP_WRITE: begin
                chk_err    = chk_err | (idx_q >= AREA_W);
                chk_result = (idx_q >= cur_size) ? (idx_q + W'(1)) : cur_size;
            end
            OP_RESIZE: begin
                chk_err    = chk_err | (idx_q > AREA_W);
                chk_result = idx_q;
            end
            OP_SHIFT_UP: begin
                chk_err    = chk_err | (cur_size == AREA_W) | (idx_q > cur_size);
                chk_moves  = cur_size - idx_q;
                chk_k      = cur_size;
                chk_result = cur_size + W'(1);
            end
            OP_SHIFT_DOWN: begin
                chk_err    = chk_err | (cur_size == '0) | (idx_q >= cur_size);
                chk_moves  = cur_size - idx_q - W'(1);
                chk_k      = idx_q;
                chk_result = mv_data;
            end
            default: ;
        endcase
        if (chk_err) begin
            chk_moves  = '0;
            chk_result = '0;
        end
    end

    // Command fields captured on the accept edge.
    always_ff @(posedge clock) begin
        if (accept) begin
            op_q  <= op_t'(bus.cmd_op);
            arr_q <= bus.cmd_array;
            idx_q <= bus.cmd_index;
            val_q <= bus.cmd_value;
        end
    end

    // Mover bookkeeping: loaded in CHECK, then one step per MOVE edge.
    always_ff @(posedge clock) begin
        if (state == S_CHECK) begin
            err_q    <= chk_err;
            result_q <= chk_result;
            size_q   <= cur_size;
            k_q      <= chk_k;
            cnt_q    <= chk_moves;
        end else if (state == S_MOVE) begin
            cnt_q <= cnt_q - W'(1);
            k_q   <= (op_q == OP_SHIFT_UP) ? (k_q - W'(1)) : (k_q + W'(1));
        end
    end

    // Mover read: the element being removed in CHECK, the neighbour of k during MOVE.
    always_comb begin
        mv_addr = cur_base + AW'(idx_q);
        if (state == S_MOVE) begin
            if (op_q == OP_SHIFT_UP) begin
                mv_addr = cur_base + AW'(k_q - W'(1));
            end else begin
                mv_addr = cur_base + AW'(k_q + W'(1));
            end
        end
    end

    // Heap write: shifted element during MOVE, inserted value or vacated tail in COMMIT.
    always_comb begin
        we    = 1'b0;
        waddr = cur_base + AW'(k_q);
        wdata = mv_data;
        if (state == S_MOVE) begin
            we = 1'b1;
        end else if (state == S_COMMIT) begin
            case (op_q)
                OP_WRITE, OP_SHIFT_UP: begin
                    we    = 1'b1;
                    waddr = cur_base + AW'(idx_q);
                    wdata = val_q;
                end
                OP_SHIFT_DOWN: begin
                    we    = 1'b1;
                    waddr = cur_base + AW'(size_q - W'(1));
                    wdata = '0;
                end
                default: ;
            endcase
        end
    end

    assign commit_size = (op_q == OP_SHIFT_DOWN) ? (size_q - W'(1)) : result_q;

    // Size table: cleared by reset, updated once per legal command in COMMIT.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NArrays; i++) begin
                size_tab[i] <= '0;
            end
        end else if (state == S_COMMIT) begin
            size_tab[arr_sel] <= commit_size;
        end
    end

    assign rd_ok   = (bus.rd_array < ARRAYS_W) && (bus.rd_index < AREA_W);
    assign rd_addr = AW'(bus.rd_array) * AW'(NArea) + AW'(bus.rd_index);

    // Fetch-side size register, independent of the command state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bus.rd_size <= '0;
        end else begin
            bus.rd_size <= (bus.rd_array < ARRAYS_W) ? size_tab[SW'(bus.rd_array)] : '0;
        end
    end

    array_heap_ram #(
        .W     (W),
        .DEPTH (NArea*NArrays),
        .AW    (AW)
    ) u_heap (
        .clock   (clock),
        .reset   (reset),
        .we      (we),
        .waddr   (waddr),
        .wdata   (wdata),
        .mv_addr (mv_addr),
        .mv_data (mv_data),
        .rd_en   (rd_ok),
        .rd_addr (rd_addr),
        .rd_data (bus.rd_data)
    );

endmodule

// File: tb/tb_array_shift_engine.sv
// Directed bench for array_shift_engine.
module tb_array_shift_engine;

    logic clock;
    logic reset;
    int   tests = 0;
    int   fails = 0;

    array_shift_engine_if #(.MemoryElementWidth(12)) bus ();

    array_shift_engine #(
        .MemoryElementWidth (12),
        .NArea              (4),
        .NArrays            (2)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Issue one command, wait for done, check latency (cycles from accept), err, result.
    task automatic run_cmd(input string tag, input logic [1:0] op, input int arr, input int idx,
                           input int val, input logic exp_err, input int exp_res, input int exp_lat);
        int cyc;
        bit seen;
        @(negedge clock);
        bus.cmd_op    = op;
        bus.cmd_array = 12'(arr);
        bus.cmd_index = 12'(idx);
        bus.cmd_value = 12'(val);
        bus.cmd_valid = 1'b1;
        cyc = 0;
        while (!bus.cmd_ready && cyc < 20) begin
            @(negedge clock);
            cyc++;
        end
        check({tag, " ready"}, bus.cmd_ready, 1);
        @(posedge clock);
        #1 bus.cmd_valid = 1'b0;
        cyc  = 0;
        seen = 0;
        while (!seen && cyc < 30) begin
            @(negedge clock);
            cyc++;
            if (bus.done) seen = 1;
        end
        check({tag, " done"}, seen, 1);
        check({tag, " latency"}, cyc, exp_lat);
        check({tag, " err"}, bus.err, exp_err);
        check({tag, " result"}, bus.result, exp_res);
        @(negedge clock);
        check({tag, " pulse"}, bus.done, 0);
    endtask

    task automatic read_chk(input string tag, input int arr, input int idx,
                            input int exp_data, input int exp_size);
        @(negedge clock);
        bus.rd_array = 12'(arr);
        bus.rd_index = 12'(idx);
        @(posedge clock);
        #1;
        check({tag, " rd_data"}, bus.rd_data, exp_data);
        check({tag, " rd_size"}, bus.rd_size, exp_size);
    endtask

    initial begin
        int  cyc;
        int  low;
        bit  seen;

        reset         = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'd0;
        bus.cmd_array = '0;
        bus.cmd_index = '0;
        bus.cmd_value = '0;
        bus.rd_array  = '0;
        bus.rd_index  = 12'd4;
        repeat (2) @(negedge clock);
        check("rst cmd_ready", bus.cmd_ready, 1);
        check("rst done", bus.done, 0);
        check("rst err", bus.err, 0);
        check("rst result", bus.result, 0);
        check("rst rd_data", bus.rd_data, 0);
        check("rst rd_size", bus.rd_size, 0);
        reset = 1'b1;

        read_chk("init a0", 0, 4, 0, 0);
        read_chk("init a1", 1, 4, 0, 0);

        // Basic insert on array 1
        run_cmd("w a1[0]", 2'd0, 1, 0, 0, 0, 1, 3);
        run_cmd("w a1[1]", 2'd0, 1, 1, 1, 0, 2, 3);
        run_cmd("w a1[2]", 2'd0, 1, 2, 2, 0, 3, 3);
        run_cmd("resize a1 3", 2'd1, 1, 3, 0, 0, 3, 3);
        run_cmd("up a1 i0", 2'd2, 1, 0, 99, 0, 4, 6);
        read_chk("a1[0]", 1, 0, 99, 4);
        read_chk("a1[1]", 1, 1, 0, 4);
        read_chk("a1[2]", 1, 2, 1, 4);
        read_chk("a1[3]", 1, 3, 2, 4);

        // Mid insert and append on array 0
        run_cmd("w a0[0]", 2'd0, 0, 0, 5, 0, 1, 3);
        run_cmd("w a0[1]", 2'd0, 0, 1, 6, 0, 2, 3);
        run_cmd("up a0 i5 bad", 2'd2, 0, 5, 1, 1, 0, 2);
        run_cmd("up a0 i1", 2'd2, 0, 1, 7, 0, 3, 4);
        run_cmd("up a0 append", 2'd2, 0, 3, 8, 0, 4, 3);
        read_chk("a0[0]", 0, 0, 5, 4);
        read_chk("a0[1]", 0, 1, 7, 4);
        read_chk("a0[2]", 0, 2, 6, 4);
        read_chk("a0[3]", 0, 3, 8, 4);

        // Error cases
        run_cmd("up a0 full", 2'd2, 0, 0, 9, 1, 0, 2);
        read_chk("a0[0] kept", 0, 0, 5, 4);
        run_cmd("w arr2", 2'd0, 2, 0, 3, 1, 0, 2);
        run_cmd("down arr800", 2'd3, 12'h800, 0, 0, 1, 0, 2);
        run_cmd("w a0 i4", 2'd0, 0, 4, 3, 1, 0, 2);
        run_cmd("resize a0 5", 2'd1, 0, 5, 0, 1, 0, 2);
        read_chk("a0[3] kept", 0, 3, 8, 4);

        // Delete
        run_cmd("down a1 i1", 2'd3, 1, 1, 0, 0, 0, 5);
        read_chk("a1[0] del", 1, 0, 99, 3);
        read_chk("a1[1] del", 1, 1, 1, 3);
        read_chk("a1[2] del", 1, 2, 2, 3);
        read_chk("a1[3] del", 1, 3, 0, 3);
        run_cmd("down a1 i3", 2'd3, 1, 3, 0, 1, 0, 2);
        run_cmd("resize a0 0", 2'd1, 0, 0, 0, 0, 0, 3);
        run_cmd("down a0 empty", 2'd3, 0, 0, 0, 1, 0, 2);
        run_cmd("resize a0 4", 2'd1, 0, 4, 0, 0, 4, 3);
        read_chk("a0[3] resize", 0, 3, 8, 4);

        // Handshake: second command held valid while the first shifts
        @(negedge clock);
        bus.cmd_op    = 2'd2;
        bus.cmd_array = 12'd1;
        bus.cmd_index = 12'd0;
        bus.cmd_value = 12'd50;
        bus.cmd_valid = 1'b1;
        @(posedge clock);
        #1;
        bus.cmd_op    = 2'd3;
        bus.cmd_index = 12'd0;
        bus.cmd_value = 12'd0;
        low  = 0;
        seen = 0;
        cyc  = 0;
        while (cyc < 30) begin
            @(negedge clock);
            cyc++;
            if (bus.done) begin
                seen = 1;
                check("hs A result", bus.result, 4);
                check("hs A err", bus.err, 0);
            end
            if (bus.cmd_ready) break;
            low++;
        end
        check("hs A done", seen, 1);
        check("hs ready low", low, 6);
        @(posedge clock);
        #1 bus.cmd_valid = 1'b0;
        seen = 0;
        cyc  = 0;
        while (!seen && cyc < 30) begin
            @(negedge clock);
            cyc++;
            if (bus.done) seen = 1;
        end
        check("hs B done", seen, 1);
        check("hs B latency", cyc, 6);
        check("hs B result", bus.result, 50);
        read_chk("hs a1[0]", 1, 0, 99, 3);
        read_chk("hs a1[2]", 1, 2, 2, 3);
        read_chk("hs a1[3]", 1, 3, 0, 3);

        // Out-of-range reads
        read_chk("rd arr2", 2, 0, 0, 0);
        read_chk("rd idx4", 1, 4, 0, 3);

        // Reset during MOVE
        @(negedge clock);
        bus.cmd_op    = 2'd2;
        bus.cmd_array = 12'd1;
        bus.cmd_index = 12'd0;
        bus.cmd_value = 12'd77;
        bus.cmd_valid = 1'b1;
        @(posedge clock);
        #1 bus.cmd_valid = 1'b0;
        repeat (3) @(posedge clock);
        #2 reset = 1'b0;
        #1;
        check("mid rst ready", bus.cmd_ready, 1);
        check("mid rst done", bus.done, 0);
        check("mid rst rd_size", bus.rd_size, 0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        seen = 0;
        repeat (6) begin
            @(negedge clock);
            if (bus.done) seen = 1;
        end
        check("mid rst no done", seen, 0);
        read_chk("post rst a0", 0, 4, 0, 0);
        read_chk("post rst a1", 1, 4, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/array_shift_engine.md
Name: array_shift_engine

Overview:
- Multi-cycle engine owning a banked heap of NArrays fixed-size areas, each NArea elements, plus a per-array size table.
- Executes array instructions (write, resize, shift-up insert, shift-down delete) for the zero VM FPGA target.
- Replaces single-cycle, loop-unrolled shifts with a bounded one-element-per-clock mover behind a valid/ready command port.
- Provides a registered read port for instruction fetch of elements and sizes.

Parameters:
- MemoryElementWidth, 12, element and data width.
- NArea, 4, elements per array area; also the maximum array size.
- NArrays, 2, number of array areas.
- AW, $clog2(NArea*NArrays), heap address width (derived; do not override).

Ports:
- clock  input  1  single clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  engine idle; a command is accepted on an edge where cmd_valid && cmd_ready.
- cmd_op  input  2  0=WRITE, 1=RESIZE, 2=SHIFT_UP, 3=SHIFT_DOWN.
- cmd_array  input  MemoryElementWidth  array number.
- cmd_index  input  MemoryElementWidth  element position (WRITE/SHIFT), or new size (RESIZE).
- cmd_value  input  MemoryElementWidth  value to write or insert.
- done  output  1  one-cycle pulse when a command retires.
- err  output  1  valid with done; command rejected with no state change.
- result  output  MemoryElementWidth  valid with done; removed element (SHIFT_DOWN), new size (other ops), 0 on error.
- rd_array  input  MemoryElementWidth  read port array number.
- rd_index  input  MemoryElementWidth  read port element position.
- rd_data  output  MemoryElementWidth  heap[rd_array*NArea+rd_index]; 1-cycle latency; 0 if out of range.
- rd_size  output  MemoryElementWidth  size of rd_array; 1-cycle latency.

Behaviour:
- Reset (reset low, asynchronous):
  - Outputs: cmd_ready=1, done=0, err=0, result=0, rd_data=0, rd_size=0.
  - Every size entry cleared to 0; state returns to IDLE.
  - Heap contents are not reset.
  - Reset mid-operation aborts the command with no done pulse; heap is left partially shifted.
- States and transitions:
  - IDLE to CHECK on accept. Command fields are latched at acceptance; cmd_ready=0 outside IDLE.
  - CHECK to DONE if the command is illegal, else to MOVE (when N>0) or COMMIT.
  - MOVE runs N edges, one element per edge; then COMMIT, then DONE, then IDLE.
  - done is registered: high for exactly one cycle in DONE.
- Errors (err=1, nothing modified):
  - Any op with cmd_array >= NArrays.
  - WRITE with index >= NArea.
  - RESIZE with index > NArea.
  - SHIFT_UP with size == NArea (full) or index > size.
  - SHIFT_DOWN with size == 0 (empty) or index >= size.
- WRITE (N=0): COMMIT writes heap[base+index]=value; size = max(size, index+1).
- RESIZE (N=0): COMMIT sets size=index; heap is untouched.
- SHIFT_UP, N = size-index:
  - MOVE runs k = size down to index+1, heap[base+k] = heap[base+k-1].
  - COMMIT writes heap[base+index]=value and size=size+1.
  - Index == size is a plain append (N=0).
- SHIFT_DOWN, N = size-1-index:
  - result latched in CHECK from heap[base+index].
  - MOVE runs k = index up to size-2, heap[base+k] = heap[base+k+1].
  - COMMIT clears heap[base+size-1] to 0 and sets size=size-1.
- Latency:
  - Accept edge T; done high in the cycle after edge T+N+2.
  - Errors: done high in the cycle after edge T+1.
- Arithmetic:
  - base = array*NArea, computed at AW bits.
  - Size arithmetic in MemoryElementWidth bits; sizes never exceed NArea, so no wrap.
- Read port:
  - Sampled every edge and independent of the command state.
  - A read of an element being written on the same edge returns the old value.

Decomposition:
- Package array_shift_pkg holds:
  - op enum (OP_WRITE, OP_RESIZE, OP_SHIFT_UP, OP_SHIFT_DOWN);
  - state enum (S_IDLE, S_CHECK, S_MOVE, S_COMMIT, S_DONE);
  - default width constants.
- One sub-module, array_heap_ram:
  - heap storage with one synchronous write port and two read ports (mover, rd_*);
  - the size table stays in the engine.

Test Plan:
- Basic insert: WRITE arr1 idx0..2 = 0,1,2; RESIZE arr1 to 3; SHIFT_UP arr1 idx0 val99 -> done after 3 moves, result=4, err=0. Reading idx0..3 gives 99,0,1,2; rd_size=4.
- Mid insert: arr0 = 5,6 (size 2); SHIFT_UP idx1 val7 -> contents 5,7,6, size 3, N=1 latency. Then append with SHIFT_UP idx3 val8 -> 5,7,6,8, N=0.
- Full and bad index: SHIFT_UP on size-4 array -> err=1, done one cycle after CHECK, contents unchanged. SHIFT_UP idx5 on size 2 -> err=1. Any op with cmd_array=2 -> err=1.
- Delete: arr1 = 99,0,1,2; SHIFT_DOWN idx1 -> result=0, contents 99,1,2,0, size 3. SHIFT_DOWN on an empty array -> err=1, result=0.
- Handshake: hold cmd_valid through a 4-cycle shift with a second command queued -> cmd_ready stays 0 until IDLE; the second command is accepted only afterwards and both retire in order.
- Reset mid-MOVE: assert reset low at move 2 -> done never pulses; cmd_ready=1 and every rd_size=0 immediately, without waiting for a clock edge.
